// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the multi-bank processing element.
//   - default operand, accumulator and bank-count widths
//   - acc_max / acc_min: saturation bounds for a signed accumulator of width w
//   - pe_mode_e: operand interpretation for one MAC operation
package pe_pkg;

    localparam int PE_DATA_W    = 8;
    localparam int PE_ACC_W     = 32;
    localparam int PE_NUM_BANKS = 2;

    // Widest accumulator the bound helpers can describe.
    localparam int PE_MAX_W = 64;

    typedef enum logic {
        PE_UNSIGNED = 1'b0,
        PE_SIGNED   = 1'b1
    } pe_mode_e;

    // Largest signed value in w bits (+2^(w-1)-1), right-aligned in PE_MAX_W bits.
    function automatic logic [PE_MAX_W-1:0] acc_max(input int w);
        return (PE_MAX_W'(1) << (w - 1)) - PE_MAX_W'(1);
    endfunction

    // Bit pattern of the most negative signed value in w bits (-2^(w-1));
    // only the low w bits are meaningful.
    function automatic logic [PE_MAX_W-1:0] acc_min(input int w);
        return PE_MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/pe_mac.sv
// pe_mac: combinational multiply-accumulate for one PE.
//   act, weight : DATA_W operands, interpreted per mode
//   psum        : ACC_W two's-complement partial sum
//   mode        : PE_SIGNED sign-extends both operands, PE_UNSIGNED zero-extends
//   result      : ACC_W sum, wrapped or (with PE_SAT_EN) clamped
//   ovf         : true sum does not fit in signed ACC_W
// Build option: define PE_SAT_EN to saturate instead of wrap.
module pe_mac
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ACC_W  = PE_ACC_W
) (
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] weight,
    input  logic [ACC_W-1:0]  psum,
    input  pe_mode_e          mode,
    output logic [ACC_W-1:0]  result,
    output logic              ovf
);

`ifdef PE_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));
`endif

    logic signed [DATA_W:0]     act_x;
    logic signed [DATA_W:0]     weight_x;
    logic signed [2*DATA_W+1:0] prod;
    logic signed [ACC_W:0]      prod_x;
    logic signed [ACC_W:0]      psum_x;
    logic signed [ACC_W:0]      sum;

    // ACC_W >= 2*DATA_W+1 guarantees the ACC_W+1 sum itself never wraps,
    // so its top two bits disagree exactly when the signed ACC_W range is exceeded.
    always_comb begin
        act_x    = {(mode == PE_SIGNED) && act[DATA_W-1], act};
        weight_x = {(mode == PE_SIGNED) && weight[DATA_W-1], weight};
        prod     = act_x * weight_x;
        prod_x   = (ACC_W+1)'(prod);
        psum_x   = (ACC_W+1)'($signed(psum));
        sum      = prod_x + psum_x;
        ovf      = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef PE_SAT_EN
        if (ovf) begin
            result = sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            result = sum[ACC_W-1:0];
        end
`else
        result   = sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/pe_mb.sv
// pe_mb: parametrised multi-bank processing element for the systolic array.
// Weights, bank tags and partial sums flow north->south; activations, valid,
// switch, select and mode flow west->east. All outputs are registered.
//   clk, rst_n             : clock, asynchronous active-low reset
//   pe_enabled             : low = synchronous clear of all state (highest priority)
//   pe_psum_in/out         : ACC_W partial sum north in, south out
//   pe_weight_in/out       : weight, forwarded south
//   pe_accept_w_in/out     : load weight into bank pe_wbank_in
//   pe_wbank_in/out        : target bank of the load
//   pe_input_in/out        : activation, forwarded east
//   pe_valid_in/out        : activation valid
//   pe_switch_in/out       : make bank pe_sel_in active
//   pe_sel_in/out          : bank to activate
//   pe_signed_in/out       : 1 = signed operands, 0 = unsigned
//   pe_ovf_out             : sticky overflow flag
//   pe_active_bank         : current active bank
// Build option: PE_SAT_EN selects saturating instead of wrapping psum (see pe_mac).
module pe_mb
    import pe_pkg::*;
#(
    parameter int   DATA_W    = PE_DATA_W,
    parameter int   ACC_W     = PE_ACC_W,
    parameter int   NUM_BANKS = PE_NUM_BANKS,
    localparam int  BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ACC_W-1:0]  pe_psum_in,
    input  logic [DATA_W-1:0] pe_weight_in,
    input  logic              pe_accept_w_in,
    input  logic [BANK_W-1:0] pe_wbank_in,
    input  logic [DATA_W-1:0] pe_input_in,
    input  logic              pe_valid_in,
    input  logic              pe_switch_in,
    input  logic [BANK_W-1:0] pe_sel_in,
    input  logic              pe_signed_in,
    input  logic              pe_enabled,
    output logic [ACC_W-1:0]  pe_psum_out,
    output logic [DATA_W-1:0] pe_weight_out,
    output logic              pe_accept_w_out,
    output logic [BANK_W-1:0] pe_wbank_out,
    output logic [DATA_W-1:0] pe_input_out,
    output logic              pe_valid_out,
    output logic              pe_switch_out,
    output logic [BANK_W-1:0] pe_sel_out,
    output logic              pe_signed_out,
    output logic              pe_ovf_out,
    output logic [BANK_W-1:0] pe_active_bank
);

    logic [DATA_W-1:0] bank [NUM_BANKS];
    logic [ACC_W-1:0]  mac_result;
    logic              mac_ovf;
    pe_mode_e          mac_mode;
    logic              load_ok;
    logic              switch_ok;

    // Indices beyond NUM_BANKS exist only when NUM_BANKS is not a power of two;
    // compare in int width so the bound itself is never truncated.
    always_comb begin
        load_ok   = pe_accept_w_in && (int'(pe_wbank_in) < NUM_BANKS);
        switch_ok = pe_switch_in && (int'(pe_sel_in) < NUM_BANKS);
        mac_mode  = pe_signed_in ? PE_SIGNED : PE_UNSIGNED;
    end

    // The MAC reads the registered bank and pointer, so a same-cycle load or
    // switch only takes effect from the next cycle.
    pe_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .act    (pe_input_in),
        .weight (bank[pe_active_bank]),
        .psum   (pe_psum_in),
        .mode   (mac_mode),
        .result (mac_result),
        .ovf    (mac_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_psum_out     <= '0;
            pe_weight_out   <= '0;
            pe_accept_w_out <= 1'b0;
            pe_wbank_out    <= '0;
            pe_input_out    <= '0;
            pe_valid_out    <= 1'b0;
            pe_switch_out   <= 1'b0;
            pe_sel_out      <= '0;
            pe_signed_out   <= 1'b0;
            pe_ovf_out      <= 1'b0;
            pe_active_bank  <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank[i] <= '0;
            end
        end else if (!pe_enabled) begin
            pe_psum_out     <= '0;
            pe_weight_out   <= '0;
            pe_accept_w_out <= 1'b0;
            pe_wbank_out    <= '0;
            pe_input_out    <= '0;
            pe_valid_out    <= 1'b0;
            pe_switch_out   <= 1'b0;
            pe_sel_out      <= '0;
            pe_signed_out   <= 1'b0;
            pe_ovf_out      <= 1'b0;
            pe_active_bank  <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            pe_weight_out   <= pe_weight_in;
            pe_accept_w_out <= pe_accept_w_in;
            pe_wbank_out    <= pe_wbank_in;
            pe_input_out    <= pe_input_in;
            pe_valid_out    <= pe_valid_in;
            pe_switch_out   <= pe_switch_in;
            pe_sel_out      <= pe_sel_in;
            pe_signed_out   <= pe_signed_in;

            if (load_ok) begin
                bank[pe_wbank_in] <= pe_weight_in;
            end
            if (switch_ok) begin
                pe_active_bank <= pe_sel_in;
            end

            if (pe_valid_in) begin
                pe_psum_out <= mac_result;
                if (mac_ovf) begin
                    pe_ovf_out <= 1'b1;
                end
            end else begin
                pe_psum_out <= pe_psum_in;
            end
        end
    end

endmodule

// File: tb/tb_pe_mb.sv
module tb_pe_mb;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int NB     = 2;
    localparam int BANK_W = 1;

    logic              clk;
    logic              rst_n;
    logic [ACC_W-1:0]  pe_psum_in;
    logic [DATA_W-1:0] pe_weight_in;
    logic              pe_accept_w_in;
    logic [BANK_W-1:0] pe_wbank_in;
    logic [DATA_W-1:0] pe_input_in;
    logic              pe_valid_in;
    logic              pe_switch_in;
    logic [BANK_W-1:0] pe_sel_in;
    logic              pe_signed_in;
    logic              pe_enabled;
    logic [ACC_W-1:0]  pe_psum_out;
    logic [DATA_W-1:0] pe_weight_out;
    logic              pe_accept_w_out;
    logic [BANK_W-1:0] pe_wbank_out;
    logic [DATA_W-1:0] pe_input_out;
    logic              pe_valid_out;
    logic              pe_switch_out;
    logic [BANK_W-1:0] pe_sel_out;
    logic              pe_signed_out;
    logic              pe_ovf_out;
    logic [BANK_W-1:0] pe_active_bank;

    pe_mb #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_BANKS(NB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pe_psum_in      (pe_psum_in),
        .pe_weight_in    (pe_weight_in),
        .pe_accept_w_in  (pe_accept_w_in),
        .pe_wbank_in     (pe_wbank_in),
        .pe_input_in     (pe_input_in),
        .pe_valid_in     (pe_valid_in),
        .pe_switch_in    (pe_switch_in),
        .pe_sel_in       (pe_sel_in),
        .pe_signed_in    (pe_signed_in),
        .pe_enabled      (pe_enabled),
        .pe_psum_out     (pe_psum_out),
        .pe_weight_out   (pe_weight_out),
        .pe_accept_w_out (pe_accept_w_out),
        .pe_wbank_out    (pe_wbank_out),
        .pe_input_out    (pe_input_out),
        .pe_valid_out    (pe_valid_out),
        .pe_switch_out   (pe_switch_out),
        .pe_sel_out      (pe_sel_out),
        .pe_signed_out   (pe_signed_out),
        .pe_ovf_out      (pe_ovf_out),
        .pe_active_bank  (pe_active_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model (integer arithmetic) ----------------
    int          m_bank [NB];
    int          m_active;
    logic [31:0] exp_psum;
    logic [7:0]  exp_weight, exp_input;
    logic        exp_accept, exp_valid, exp_switch, exp_signed, exp_ovf;
    logic [0:0]  exp_wbank, exp_sel, exp_active;

    function automatic longint opnd(input logic [7:0] v, input logic sgn);
        if (sgn && v[7]) return longint'(v) - 256;
        return longint'(v);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NB; i++) m_bank[i] = 0;
        m_active   = 0;
        exp_psum   = '0; exp_weight = '0; exp_input = '0;
        exp_accept = 0; exp_valid = 0; exp_switch = 0; exp_signed = 0; exp_ovf = 0;
        exp_wbank  = '0; exp_sel = '0; exp_active = '0;
    endtask

    initial model_clear();

    always @(posedge clk or negedge rst_n) begin
        longint sum;
        if (!rst_n || !pe_enabled) begin
            model_clear();
        end else begin
            if (pe_valid_in) begin
                sum = opnd(pe_input_in, pe_signed_in) *
                      opnd(8'(m_bank[m_active]), pe_signed_in) +
                      longint'($signed(pe_psum_in));
                if (sum > 64'sd2147483647 || sum < -64'sd2147483648) begin
                    exp_ovf = 1'b1;
`ifdef PE_SAT_EN
                    exp_psum = (sum > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
                    exp_psum = sum[31:0];
`endif
                end else begin
                    exp_psum = sum[31:0];
                end
            end else begin
                exp_psum = pe_psum_in;
            end
            if (pe_accept_w_in && int'(pe_wbank_in) < NB) m_bank[pe_wbank_in] = int'(pe_weight_in);
            if (pe_switch_in && int'(pe_sel_in) < NB) m_active = int'(pe_sel_in);
            exp_active = 1'(m_active);
            exp_weight = pe_weight_in; exp_accept = pe_accept_w_in; exp_wbank = pe_wbank_in;
            exp_input  = pe_input_in;  exp_valid  = pe_valid_in;    exp_switch = pe_switch_in;
            exp_sel    = pe_sel_in;    exp_signed = pe_signed_in;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        cmp("psum_out",     64'(pe_psum_out),     64'(exp_psum));
        cmp("weight_out",   64'(pe_weight_out),   64'(exp_weight));
        cmp("accept_w_out", 64'(pe_accept_w_out), 64'(exp_accept));
        cmp("wbank_out",    64'(pe_wbank_out),    64'(exp_wbank));
        cmp("input_out",    64'(pe_input_out),    64'(exp_input));
        cmp("valid_out",    64'(pe_valid_out),    64'(exp_valid));
        cmp("switch_out",   64'(pe_switch_out),   64'(exp_switch));
        cmp("sel_out",      64'(pe_sel_out),      64'(exp_sel));
        cmp("signed_out",   64'(pe_signed_out),   64'(exp_signed));
        cmp("ovf_out",      64'(pe_ovf_out),      64'(exp_ovf));
        cmp("active_bank",  64'(pe_active_bank),  64'(exp_active));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        pe_accept_w_in = 0; pe_switch_in = 0; pe_valid_in = 0;
        pe_weight_in = '0; pe_wbank_in = '0; pe_sel_in = '0;
        pe_input_in = '0; pe_psum_in = '0; pe_signed_in = 0;
    endtask

    task automatic load(input logic [0:0] b, input logic [7:0] w);
        idle(); pe_accept_w_in = 1; pe_wbank_in = b; pe_weight_in = w; tick();
    endtask

    task automatic mac(input logic [7:0] a, input logic [31:0] p, input logic sgn);
        idle(); pe_valid_in = 1; pe_input_in = a; pe_psum_in = p; pe_signed_in = sgn; tick();
    endtask

    initial begin
        idle();
        pe_enabled = 1;
        rst_n = 0;
        tick(); tick();
        cmp("reset_psum",   64'(pe_psum_out),    64'd0);
        cmp("reset_active", 64'(pe_active_bank), 64'd0);
        cmp("reset_ovf",    64'(pe_ovf_out),     64'd0);
        rst_n = 1;

        // bank0=3, bank1=-2, switch to 1, 5*(-2)+10 = 0
        load(1'b0, 8'd3);
        load(1'b1, 8'hFE);
        idle(); pe_switch_in = 1; pe_sel_in = 1'b1; tick();
        cmp("switch_active", 64'(pe_active_bank), 64'd1);
        mac(8'd5, 32'd10, 1'b1);
        cmp("tp1_psum", 64'(pe_psum_out), 64'd0);
        cmp("tp1_active", 64'(pe_active_bank), 64'd1);

        // 0xFF * 0xFF unsigned and signed
        load(1'b1, 8'hFF);
        mac(8'hFF, 32'd0, 1'b0);
        cmp("unsigned_ff", 64'(pe_psum_out), 64'd65025);
        mac(8'hFF, 32'd0, 1'b1);
        cmp("signed_ff", 64'(pe_psum_out), 64'd1);
        mac(8'hFF, 32'hFFFF_FFF0, 1'b1);
        cmp("signed_neg_psum", 64'(pe_psum_out), 64'hFFFF_FFF1);

        // valid low: passthrough, no overflow even at the edge of range
        idle(); pe_psum_in = 32'h7FFF_FFFF; pe_input_in = 8'h7F; tick();
        cmp("passthru_max", 64'(pe_psum_out), 64'h7FFF_FFFF);
        cmp("passthru_noovf", 64'(pe_ovf_out), 64'd0);

        // positive overflow
        load(1'b1, 8'd1);
        mac(8'd1, 32'h7FFF_FFFF, 1'b1);
`ifdef PE_SAT_EN
        cmp("ovf_pos_psum", 64'(pe_psum_out), 64'h7FFF_FFFF);
`else
        cmp("ovf_pos_psum", 64'(pe_psum_out), 64'h8000_0000);
`endif
        cmp("ovf_pos_flag", 64'(pe_ovf_out), 64'd1);
        for (int i = 0; i < 10; i++) begin
            mac(8'd0, 32'd0, 1'b1);
            cmp("ovf_sticky", 64'(pe_ovf_out), 64'd1);
        end

        // negative overflow: -1*1 + -2^31
        mac(8'hFF, 32'h8000_0000, 1'b1);
`ifdef PE_SAT_EN
        cmp("ovf_neg_psum", 64'(pe_psum_out), 64'h8000_0000);
`else
        cmp("ovf_neg_psum", 64'(pe_psum_out), 64'h7FFF_FFFF);
`endif

        // enable low for one cycle clears everything
        idle(); pe_enabled = 0; pe_valid_in = 1; pe_input_in = 8'd9; pe_psum_in = 32'd77;
        pe_accept_w_in = 1; pe_weight_in = 8'd9; tick();
        pe_enabled = 1;
        cmp("dis_psum",   64'(pe_psum_out),    64'd0);
        cmp("dis_ovf",    64'(pe_ovf_out),     64'd0);
        cmp("dis_active", 64'(pe_active_bank), 64'd0);
        cmp("dis_weight", 64'(pe_weight_out),  64'd0);
        cmp("dis_valid",  64'(pe_valid_out),   64'd0);
        mac(8'd4, 32'd123, 1'b1);
        cmp("dis_bank0_zero", 64'(pe_psum_out), 64'd123);
        idle(); pe_switch_in = 1; pe_sel_in = 1'b1; tick();
        mac(8'd4, 32'd55, 1'b0);
        cmp("dis_bank1_zero", 64'(pe_psum_out), 64'd55);
        idle(); pe_switch_in = 1; pe_sel_in = 1'b0; tick();

        // same-cycle load bank1=7 and switch to 1
        idle(); pe_accept_w_in = 1; pe_wbank_in = 1'b1; pe_weight_in = 8'd7;
        pe_switch_in = 1; pe_sel_in = 1'b1; tick();
        mac(8'd2, 32'd0, 1'b1);
        cmp("load_switch_psum", 64'(pe_psum_out), 64'd14);
        idle(); pe_psum_in = 32'd42; tick();
        cmp("valid_low_psum", 64'(pe_psum_out), 64'd42);

        // load into the active bank while valid: old weight this cycle
        idle(); pe_valid_in = 1; pe_input_in = 8'd3; pe_signed_in = 1;
        pe_accept_w_in = 1; pe_wbank_in = 1'b1; pe_weight_in = 8'd5; tick();
        cmp("load_active_old", 64'(pe_psum_out), 64'd21);
        mac(8'd3, 32'd0, 1'b1);
        cmp("load_active_new", 64'(pe_psum_out), 64'd15);

        // switch to already-active bank
        idle(); pe_switch_in = 1; pe_sel_in = 1'b1; tick();
        cmp("reswitch_active", 64'(pe_active_bank), 64'd1);
        mac(8'd2, 32'd1, 1'b0);
        cmp("reswitch_psum", 64'(pe_psum_out), 64'd11);

        // asynchronous reset mid-stream
        idle(); pe_valid_in = 1; pe_input_in = 8'd6; pe_psum_in = 32'd100;
        pe_weight_in = 8'hAA; pe_signed_in = 1; tick();
        #1 rst_n = 0;
        #1;
        cmp("async_psum",   64'(pe_psum_out),    64'd0);
        cmp("async_weight", 64'(pe_weight_out),  64'd0);
        cmp("async_valid",  64'(pe_valid_out),   64'd0);
        cmp("async_active", 64'(pe_active_bank), 64'd0);
        cmp("async_signed", 64'(pe_signed_out),  64'd0);
        tick();
        rst_n = 1;
        idle(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
